// File: rtl/arcade_input_mapper.sv
// Maps MiSTer ps2_key events and hps_io joystick words onto active-low arcade controls for 1..4 players.
// Optional autofire on joystick bit10 is compiled in when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_mapper #(
  parameter int PLAYERS       = 2,
  parameter int BUTTONS       = 1,
  parameter int COIN_PULSE    = 983040,
  parameter int COIN_GAP      = 983040,
  parameter int AUTOFIRE_HALF = 1228800
) (
  input  logic                         clk_sys,
  input  logic                         I_RESETn,
  input  logic [10:0]                  ps2_key,
  input  logic [16*PLAYERS-1:0]        joystick,
  input  logic [1:0]                   rotate,
  input  logic                         start_coin,
  output logic [4*PLAYERS-1:0]         O_DIR,
  output logic [BUTTONS*PLAYERS-1:0]   O_BTN,
  output logic [PLAYERS-1:0]           O_START,
  output logic [PLAYERS-1:0]           O_COIN
);

  localparam int CNT_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(COIN_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(COIN_GAP - 1);
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int AF_W = $clog2(AUTOFIRE_HALF + 1);
  localparam logic [AF_W-1:0] AF_LAST = AF_W'(AUTOFIRE_HALF - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } coin_state_t;

  // Input is {U,D,L,R}; output is the remapped {U,D,L,R}.
  function automatic logic [3:0] rot_dir(input logic [3:0] udlr, input logic [1:0] mode);
    logic [3:0] res;
    case (mode)
      2'd1:    res = {udlr[1], udlr[0], udlr[2], udlr[3]};
      2'd2:    res = {udlr[2], udlr[3], udlr[0], udlr[1]};
      2'd3:    res = {udlr[0], udlr[1], udlr[3], udlr[2]};
      default: res = udlr;
    endcase
    return res;
  endfunction

  logic       r_toggle;
  logic       w_evt;
  logic       w_map_vld;
  logic [1:0] w_map_p;
  logic [3:0] w_map_b;

  // Stage p0: ps2 event detection and key decode
  always_ff @(posedge clk_sys) begin
    r_toggle <= ps2_key[10];
  end

  assign w_evt = ps2_key[10] ^ r_toggle;

  // Key bit index follows the joystick layout: 0 R, 1 L, 2 D, 3 U, 4..7 fire, 8 start, 9 coin.
  always_comb begin
    w_map_vld = 1'b1;
    w_map_p   = 2'd0;
    w_map_b   = 4'd0;
    if (ps2_key[8]) begin
      case (ps2_key[7:0])
        8'h75:   w_map_b = 4'd3;
        8'h72:   w_map_b = 4'd2;
        8'h6B:   w_map_b = 4'd1;
        8'h74:   w_map_b = 4'd0;
        8'h14:   w_map_b = 4'd4;
        default: w_map_vld = 1'b0;
      endcase
    end else begin
      case (ps2_key[7:0])
        8'h29, 8'h14: w_map_b = 4'd4;
        8'h11:        w_map_b = 4'd5;
        8'h12:        w_map_b = 4'd6;
        8'h1A:        w_map_b = 4'd7;
        8'h05, 8'h16: w_map_b = 4'd8;
        8'h2E:        w_map_b = 4'd9;
        8'h2D:        begin w_map_p = 2'd1; w_map_b = 4'd3; end
        8'h2B:        begin w_map_p = 2'd1; w_map_b = 4'd2; end
        8'h23:        begin w_map_p = 2'd1; w_map_b = 4'd1; end
        8'h34:        begin w_map_p = 2'd1; w_map_b = 4'd0; end
        8'h1C:        begin w_map_p = 2'd1; w_map_b = 4'd4; end
        8'h1B:        begin w_map_p = 2'd1; w_map_b = 4'd5; end
        8'h15:        begin w_map_p = 2'd1; w_map_b = 4'd6; end
        8'h1D:        begin w_map_p = 2'd1; w_map_b = 4'd7; end
        8'h06, 8'h1E: begin w_map_p = 2'd1; w_map_b = 4'd8; end
        8'h36:        begin w_map_p = 2'd1; w_map_b = 4'd9; end
        8'h26:        begin w_map_p = 2'd2; w_map_b = 4'd8; end
        8'h3D:        begin w_map_p = 2'd2; w_map_b = 4'd9; end
        8'h25:        begin w_map_p = 2'd3; w_map_b = 4'd8; end
        8'h3E:        begin w_map_p = 2'd3; w_map_b = 4'd9; end
        default:      w_map_vld = 1'b0;
      endcase
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
    logic [9:0]         r_key;
    logic [15:0]        w_joy;
    logic [9:0]         w_raw;
    logic [3:0]         w_fire;
    logic [3:0]         r_dir;
    logic [BUTTONS-1:0] r_btn;
    logic               r_start;
    logic               r_coin;
    coin_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_pend, w_pend_nxt;
    logic               r_src_d;
    logic               w_src;
    logic               w_coin_evt;
    logic               w_unused;

    assign w_joy = joystick[16*p +: 16];

    // Stage p1: key state (players beyond PLAYERS have no register, so their keys vanish here)
    always_ff @(posedge clk_sys) begin
      if (!I_RESETn) begin
        r_key <= '0;
      end else if (w_evt && w_map_vld && (w_map_p == 2'(p))) begin
        r_key[w_map_b] <= ps2_key[9];
      end
    end

    assign w_raw = r_key | w_joy[9:0];

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic            r_af_hold;
    logic            r_phase, w_phase_nxt;
    logic [AF_W-1:0] r_af_cnt, w_af_cnt_nxt;

    always_comb begin
      w_phase_nxt  = r_phase;
      w_af_cnt_nxt = r_af_cnt;
      if (!r_af_hold) begin
        w_phase_nxt  = 1'b0;
        w_af_cnt_nxt = '0;
      end else if (r_af_cnt == AF_LAST) begin
        w_phase_nxt  = ~r_phase;
        w_af_cnt_nxt = '0;
      end else begin
        w_af_cnt_nxt = r_af_cnt + AF_W'(1);
      end
    end

    always_ff @(posedge clk_sys) begin
      if (!I_RESETn) begin
        r_af_hold <= 1'b0;
        r_phase   <= 1'b0;
        r_af_cnt  <= '0;
      end else begin
        r_af_hold <= w_joy[10];
        if (w_joy[10]) begin
          r_phase  <= w_phase_nxt;
          r_af_cnt <= w_af_cnt_nxt;
        end
      end
    end

    // The phase that will hold after this edge drives fire0, so the first hold cycle is inactive.
    assign w_fire   = {w_raw[7:5], w_joy[10] ? (w_phase_nxt & w_raw[4]) : w_raw[4]};
    assign w_unused = ^{w_joy[15:11], w_fire};
`else
    assign w_fire   = w_raw[7:4];
    assign w_unused = ^{w_joy[15:10], w_fire};
`endif

    assign w_src      = w_raw[9] | (start_coin & w_raw[8]);
    assign w_coin_evt = w_src & ~r_src_d;

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pend_nxt  = r_pend;
      case (r_state)
        S_IDLE: begin
          if (w_coin_evt) begin
            w_state_nxt = S_PULSE;
            w_cnt_nxt   = PULSE_LD;
          end
        end
        S_PULSE: begin
          w_pend_nxt = r_pend | w_coin_evt;
          if (r_cnt == '0) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = GAP_LD;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == '0) begin
            w_pend_nxt = 1'b0;
            if (r_pend || w_coin_evt) begin
              w_state_nxt = S_PULSE;
              w_cnt_nxt   = PULSE_LD;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_cnt_nxt  = r_cnt - CNT_W'(1);
            w_pend_nxt = r_pend | w_coin_evt;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    always_ff @(posedge clk_sys) begin
      if (!I_RESETn) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_pend  <= 1'b0;
        r_src_d <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_pend  <= w_pend_nxt;
        r_src_d <= w_src;
      end
    end

    // Stage p2: active-low output registers
    always_ff @(posedge clk_sys) begin
      if (!I_RESETn) begin
        r_dir   <= '1;
        r_btn   <= '1;
        r_start <= 1'b1;
        r_coin  <= 1'b1;
      end else begin
        r_dir   <= ~rot_dir(w_raw[3:0], rotate);
        r_btn   <= ~w_fire[BUTTONS-1:0];
        r_start <= ~w_raw[8];
        r_coin  <= (r_state != S_PULSE);
      end
    end

    assign O_DIR[4*p +: 4]             = r_dir;
    assign O_BTN[BUTTONS*p +: BUTTONS] = r_btn;
    assign O_START[p]                  = r_start;
    assign O_COIN[p]                   = r_coin;
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Scoreboard bench for arcade_input_mapper: a 2-player/4-button instance and a 1-player instance.
module tb_arcade_input_mapper;

  localparam int AF_HALF = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] ps2 = 11'h775;
  logic [31:0] joy = '0;
  logic [1:0]  rot = 2'd0;
  logic        scoin = 1'b0;

  logic [7:0]  o_dir;
  logic [7:0]  o_btn;
  logic [1:0]  o_start;
  logic [1:0]  o_coin;
  logic [3:0]  d1_dir;
  logic [0:0]  d1_btn;
  logic [0:0]  d1_start;
  logic [0:0]  d1_coin;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [31:0] joy;
    logic [1:0]  rot;
    logic [7:0]  dir;
    logic [7:0]  btn;
    logic [1:0]  st;
  } vec_t;
  vec_t tbl[12];

  arcade_input_mapper #(
    .PLAYERS(2), .BUTTONS(4), .COIN_PULSE(4), .COIN_GAP(3), .AUTOFIRE_HALF(AF_HALF)
  ) dut (
    .clk_sys(clk), .I_RESETn(rst_n), .ps2_key(ps2), .joystick(joy), .rotate(rot),
    .start_coin(scoin), .O_DIR(o_dir), .O_BTN(o_btn), .O_START(o_start), .O_COIN(o_coin)
  );

  arcade_input_mapper #(
    .PLAYERS(1), .BUTTONS(1), .COIN_PULSE(4), .COIN_GAP(3), .AUTOFIRE_HALF(AF_HALF)
  ) dut1 (
    .clk_sys(clk), .I_RESETn(rst_n), .ps2_key(ps2), .joystick(joy[15:0]), .rotate(rot),
    .start_coin(scoin), .O_DIR(d1_dir), .O_BTN(d1_btn), .O_START(d1_start), .O_COIN(d1_coin)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int lat, input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.due  = cyc + lat;
    e.sel  = sel;
    e.exp  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic check_due();
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      case (e.sel)
        0:       act = 32'(o_dir);
        1:       act = 32'(o_btn);
        2:       act = 32'(o_start);
        3:       act = 32'(o_coin);
        4:       act = 32'({d1_dir, d1_btn, d1_start, d1_coin});
        5:       act = 32'(o_btn[0]);
        default: act = 32'({o_dir, o_btn, o_start, o_coin});
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h want=%h", e.name, cyc, act, e.exp);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_due();
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 500) begin
      step();
      n++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending=%0d", q.size());
      q.delete();
    end
  endtask

  task automatic key(input logic [7:0] code, input logic ext, input logic pr);
    ps2 = {~ps2[10], pr, ext, code};
  endtask

  initial begin
    tbl[0]  = '{32'h0000_0000, 2'd0, 8'hFF, 8'hFF, 2'b11};
    tbl[1]  = '{32'h0000_0002, 2'd1, 8'hF7, 8'hFF, 2'b11};
    tbl[2]  = '{32'h0000_0002, 2'd2, 8'hFE, 8'hFF, 2'b11};
    tbl[3]  = '{32'h0000_0002, 2'd3, 8'hFB, 8'hFF, 2'b11};
    tbl[4]  = '{32'h0000_0008, 2'd0, 8'hF7, 8'hFF, 2'b11};
    tbl[5]  = '{32'h0001_0000, 2'd0, 8'hEF, 8'hFF, 2'b11};
    tbl[6]  = '{32'h0000_00F0, 2'd0, 8'hFF, 8'hF0, 2'b11};
    tbl[7]  = '{32'h0040_0000, 2'd0, 8'hFF, 8'hBF, 2'b11};
    tbl[8]  = '{32'h0000_0100, 2'd0, 8'hFF, 8'hFF, 2'b10};
    tbl[9]  = '{32'h0000_0008, 2'd1, 8'hFE, 8'hFF, 2'b11};
    tbl[10] = '{32'h0004_0000, 2'd2, 8'h7F, 8'hFF, 2'b11};
    tbl[11] = '{32'h0000_000F, 2'd3, 8'hF0, 8'hFF, 2'b11};

    // Reset with toggle history at 1, then idle
    step();
    expect_at(1, 6, 32'hF_FFFF, "rst_state");
    expect_at(1, 4, 32'h7F, "rst_state_p1");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 0) begin
        expect_at(1, 6, 32'hF_FFFF, "idle_after_rst");
        expect_at(1, 4, 32'h7F, "idle_after_rst_p1");
      end
      step();
    end
    drain();

    // P1 up via extended 75: two-cycle latency
    key(8'h75, 1'b1, 1'b1);
    expect_at(1, 0, 32'hFF, "key_up_lat1");
    expect_at(2, 0, 32'hF7, "key_up_press");
    repeat (4) step();
    key(8'h75, 1'b1, 1'b0);
    expect_at(1, 0, 32'hF7, "key_up_rel_lat1");
    expect_at(2, 0, 32'hFF, "key_up_release");
    drain();

    // Joystick / rotation table
    for (int i = 0; i < 12; i++) begin
      joy = tbl[i].joy;
      rot = tbl[i].rot;
      expect_at(1, 0, 32'(tbl[i].dir), $sformatf("vec%0d_dir", i));
      expect_at(1, 1, 32'(tbl[i].btn), $sformatf("vec%0d_btn", i));
      expect_at(1, 2, 32'(tbl[i].st), $sformatf("vec%0d_start", i));
      step();
    end
    joy = '0;
    rot = 2'd0;
    drain();
    repeat (3) step();

    // Coin stretching: A at k=0, B during PULSE (pending), C during GAP (dropped)
    for (int k = 1; k <= 21; k++) begin
      expect_at(k, 3, ((k >= 2 && k <= 5) || (k >= 9 && k <= 12)) ? 32'h2 : 32'h3,
                $sformatf("coin_seq_k%0d", k));
    end
    for (int k = 0; k < 21; k++) begin
      joy = (k == 0 || k == 2 || k == 5) ? 32'h0000_0200 : 32'h0;
      step();
    end
    drain();
    repeat (2) step();

    // Start-inserts-coin with a held start key
    scoin = 1'b1;
    key(8'h16, 1'b0, 1'b1);
    for (int k = 1; k <= 50; k++) begin
      expect_at(k, 2, (k >= 2) ? 32'h2 : 32'h3, $sformatf("sc_start_k%0d", k));
      expect_at(k, 3, (k >= 3 && k <= 6) ? 32'h2 : 32'h3, $sformatf("sc_coin_k%0d", k));
    end
    repeat (50) step();
    key(8'h16, 1'b0, 1'b0);
    expect_at(2, 2, 32'h3, "sc_start_release");
    expect_at(2, 3, 32'h3, "sc_release_no_coin");
    drain();
    scoin = 1'b0;
    step();
    key(8'h16, 1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      expect_at(k, 2, (k >= 2) ? 32'h2 : 32'h3, $sformatf("nosc_start_k%0d", k));
      expect_at(k, 3, 32'h3, $sformatf("nosc_coin_k%0d", k));
    end
    repeat (20) step();
    key(8'h16, 1'b0, 1'b0);
    drain();
    repeat (2) step();

    // P2 keys: visible on the 2-player instance, ignored by the 1-player one
    key(8'h2D, 1'b0, 1'b1);
    expect_at(1, 4, 32'h7F, "p1only_2d_lat1");
    expect_at(2, 0, 32'h7F, "p2_up_key");
    expect_at(2, 4, 32'h7F, "p1only_2d");
    step();
    step();
    key(8'h36, 1'b0, 1'b1);
    expect_at(1, 4, 32'h7F, "p1only_36_lat1");
    expect_at(2, 4, 32'h7F, "p1only_36");
    expect_at(3, 3, 32'h1, "p2_coin_key");
    expect_at(3, 4, 32'h7F, "p1only_36_lat3");
    repeat (4) step();
    key(8'h2D, 1'b0, 1'b0);
    expect_at(2, 0, 32'hFF, "p2_up_release");
    step();
    step();
    key(8'h36, 1'b0, 1'b0);
    drain();
    repeat (10) step();

    // Autofire hold on bit10 with fire0
    joy = 32'h0000_0410;
    for (int k = 1; k <= 40; k++) begin
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      expect_at(k, 5, ((((k - 1) / AF_HALF) % 2) == 0) ? 32'h1 : 32'h0, $sformatf("af_k%0d", k));
`else
      expect_at(k, 5, 32'h0, $sformatf("af_k%0d", k));
`endif
    end
    repeat (40) step();
    joy = 32'h0000_0010;
    expect_at(1, 5, 32'h0, "af_release");
    step();
    step();
    joy = '0;
    expect_at(1, 5, 32'h1, "af_off");
    drain();

    // Reset in the middle of a coin pulse
    joy = 32'h0000_0200;
    expect_at(2, 3, 32'h2, "pulse_before_rst");
    step();
    joy = '0;
    step();
    step();
    rst_n = 1'b0;
    expect_at(1, 3, 32'h3, "rst_in_pulse");
    step();
    rst_n = 1'b1;
    step();
    step();
    expect_at(1, 6, 32'hF_FFFF, "after_rst_release");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
